// File: rtl/serializer_lvds_param_if.sv
// rtl/serializer_lvds_param_if.sv - word handshake bundle feeding the LVDS serializer
//
// Carries one parallel word per transfer from the producer (master) into the
// serializer (slave). A transfer happens on a rising edge where valid_i and
// ready_o are both high.
//   data_i  : word to send, DATA_W bits (master -> slave)
//   valid_i : data_i holds a word (master -> slave)
//   ready_o : serializer holding register is empty (slave -> master)
interface serializer_lvds_param_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] data_i;
    logic              valid_i;
    logic              ready_o;

    modport master (
        output data_i,
        output valid_i,
        input  ready_o
    );

    modport slave (
        input  data_i,
        input  valid_i,
        output ready_o
    );
endinterface

// File: rtl/serializer_lvds_param.sv
// rtl/serializer_lvds_param.sv - framed LVDS bit serializer with one-word holding register
//
// Frame: start bit (1), DATA_W payload bits, optional even-parity bit, then
// IDLE_BITS low cycles. A holding register accepts the next word while the
// current frame shifts, so queued words go out back-to-back.
// Optional feature macro: SERIALIZER_PARITY_EN (adds the parity bit).
// Ports:
//   clk      : bit clock, rising edge
//   reset    : asynchronous, active-low
//   in_if    : slave side of the word handshake (data_i, valid_i, ready_o)
//   serial_o : registered serial line
//   busy_o   : frame in progress (state != IDLE)
//   done_o   : one-cycle pulse on the first gap cycle of each frame
module serializer_lvds_param #(
    parameter int DATA_W    = 32,
    parameter int IDLE_BITS = 1,
    parameter int LSB_FIRST = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    serializer_lvds_param_if.slave in_if,
    output logic                   serial_o,
    output logic                   busy_o,
    output logic                   done_o
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef SERIALIZER_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_GAP    = 3'd4;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [3:0]       LAST_GAP = 4'(IDLE_BITS - 1);

    logic [2:0]        state, state_n;
    logic [DATA_W-1:0] shifter, shifter_n, shifted;
    logic [DATA_W-1:0] hold_data;
    logic              hold_full, hold_full_n;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [3:0]        gap_cnt, gap_cnt_n;
    logic              ready_q, serial_q, serial_n, done_q, done_n;
    logic              accept, consume;
`ifdef SERIALIZER_PARITY_EN
    logic              parity_q, parity_n;
`endif

    assign accept = in_if.valid_i && ready_q;

    // The bit on the line is always the outgoing end of the shifter.
    assign shifted = (LSB_FIRST != 0) ? {1'b0, shifter[DATA_W-1:1]}
                                      : {shifter[DATA_W-2:0], 1'b0};

    always_comb begin
        state_n   = state;
        shifter_n = shifter;
        bit_cnt_n = bit_cnt;
        gap_cnt_n = gap_cnt;
        consume   = 1'b0;
`ifdef SERIALIZER_PARITY_EN
        parity_n  = parity_q;
`endif
        case (state)
            S_IDLE: begin
                if (hold_full) begin
                    consume = 1'b1;
                    state_n = S_START;
                end
            end
            S_START: begin
                state_n   = S_DATA;
                bit_cnt_n = '0;
            end
            S_DATA: begin
                if (bit_cnt == LAST_BIT) begin
                    gap_cnt_n = '0;
`ifdef SERIALIZER_PARITY_EN
                    state_n   = S_PARITY;
`else
                    state_n   = S_GAP;
`endif
                end else begin
                    bit_cnt_n = bit_cnt + CNT_W'(1);
                    shifter_n = shifted;
                end
            end
`ifdef SERIALIZER_PARITY_EN
            S_PARITY: begin
                state_n   = S_GAP;
                gap_cnt_n = '0;
            end
`endif
            S_GAP: begin
                if (gap_cnt == LAST_GAP) begin
                    if (hold_full) begin
                        consume = 1'b1;
                        state_n = S_START;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    gap_cnt_n = gap_cnt + 4'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Parity comes from the word as loaded, since the shifter is
        // destroyed while the payload goes out.
        if (consume) begin
            shifter_n = hold_data;
`ifdef SERIALIZER_PARITY_EN
            parity_n  = ^hold_data;
`endif
        end

        // ready_q is low whenever hold_full is set, so accept and consume
        // can never fire on the same edge.
        hold_full_n = consume ? 1'b0 : (accept ? 1'b1 : hold_full);

        // Line value is decoded from the state being entered so serial_o
        // can be a flop and still line up with the state.
        case (state_n)
            S_START:  serial_n = 1'b1;
            S_DATA:   serial_n = (LSB_FIRST != 0) ? shifter_n[0] : shifter_n[DATA_W-1];
`ifdef SERIALIZER_PARITY_EN
            S_PARITY: serial_n = parity_n;
`endif
            default:  serial_n = 1'b0;
        endcase

        done_n = (state_n == S_GAP) && (state != S_GAP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            shifter   <= '0;
            hold_data <= '0;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            ready_q   <= 1'b0;
            serial_q  <= 1'b0;
            done_q    <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            shifter   <= shifter_n;
            hold_full <= hold_full_n;
            bit_cnt   <= bit_cnt_n;
            gap_cnt   <= gap_cnt_n;
            ready_q   <= !hold_full_n;
            serial_q  <= serial_n;
            done_q    <= done_n;
`ifdef SERIALIZER_PARITY_EN
            parity_q  <= parity_n;
`endif
            if (accept) begin
                hold_data <= in_if.data_i;
            end
        end
    end

    assign in_if.ready_o = ready_q;
    assign serial_o      = serial_q;
    assign busy_o        = (state != S_IDLE);
    assign done_o        = done_q;
endmodule

// File: doc/serializer_lvds_param.md
# serializer_lvds_param

Parametrised LVDS frame serializer for the F2F TX path: takes parallel words over a valid/ready handshake and shifts them out one bit per clock as framed serial frames. Each frame is a start marker, a configurable-width payload, an optional parity bit and a configurable idle gap. A one-word holding register lets the next word be accepted while the current frame is still shifting, so back-to-back frames run with no extra idle. The block feeds the LVDS output buffer; its RX counterpart on the far FPGA locks to the start marker.

## Interface
- DATA_W, 32, payload width in bits; legal 8..64
- IDLE_BITS, 1, minimum low cycles between frames; legal 1..15
- LSB_FIRST, 0, 0: payload MSB first; 1: LSB first
- clk  input  1  bit clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- data_i  input  DATA_W  word to send; sampled only on acceptance
- valid_i  input  1  data_i valid
- ready_o  output  1  holding register empty, word will be accepted
- serial_o  output  1  registered serial line
- busy_o  output  1  frame in progress (state != IDLE)
- done_o  output  1  one-cycle pulse on first GAP cycle of each frame

## Operation
- Acceptance: valid_i && ready_o at a rising edge writes data_i into the holding register, sets hold_full. ready_o = !hold_full, registered.
- FSM states: IDLE, START, DATA, PARITY, GAP.
- IDLE: serial_o=0. If hold_full: load shifter from holding register, clear hold_full, go START.
- START: serial_o=1 for one cycle; go DATA, bit counter=0.
- DATA: serial_o = shifter MSB (LSB if LSB_FIRST); shift each cycle; counter increments; after DATA_W bits go PARITY (macro on) else GAP.
- PARITY: serial_o = even parity bit (XOR of all payload bits) for one cycle; go GAP.
- GAP: serial_o=0 for IDLE_BITS cycles; done_o=1 on first GAP cycle only. On last GAP cycle: if hold_full, load shifter, clear hold_full, go START; else go IDLE.
- Bit counter width $clog2(DATA_W+1); gap counter 4 bits; no counter wraps within a frame.
- Parity computed from the word at load time, not from the shifting register.
- Holding register consumption and new acceptance never coincide: ready_o is 0 on the edge the full register is consumed; the next word is accepted one edge later.
- data_i/valid_i ignored whenever ready_o=0; valid_i may drop without acceptance (no stickiness required).

## Timing
- Reset (reset low, asynchronous): state=IDLE, serial_o=0, busy_o=0, done_o=0, ready_o=0, hold_full=0, shifter=0. ready_o rises on the first clk edge after reset released.
- Reset mid-frame: frame aborted immediately, line low, held word discarded.
- Latency: word accepted at edge E0 with FSM IDLE → FSM enters START at E1, start bit on serial_o during E1..E2, payload bit 0 during E2..E3.
- Frame length FL = 1 + DATA_W + P + IDLE_BITS cycles (P=1 with parity). Back-to-back: start bits exactly FL cycles apart while a word is always waiting.
- busy_o high from START through last GAP cycle; stays high continuously across back-to-back frames.

## Configuration
- SERIALIZER_PARITY_EN defined: PARITY state present; one even-parity bit follows the payload; FL includes it.
- Not defined: PARITY state removed; DATA goes straight to GAP; FL = 1 + DATA_W + IDLE_BITS.

## Test plan
- Single word, defaults, macro off: send 0xA5A5_0F0F → serial_o: 1, then bits 1010 0101 1010 0101 0000 1111 0000 1111, then 0; done_o pulses once; busy_o high 34 cycles.
- Back-to-back: hold valid_i high with 0xFFFF_FFFF, 0x0000_0001 → second start bit exactly 34 cycles after first; ready_o low one cycle after each acceptance until register consumed.
- LSB_FIRST=1, DATA_W=8: send 0x01 → start bit, then 1, then seven 0s, then IDLE_BITS low cycles.
- SERIALIZER_PARITY_EN, DATA_W=8: send 0x07 → parity bit 1 after payload; send 0x03 → parity bit 0; FL=11 with IDLE_BITS=1.
- IDLE_BITS=4: two queued words → exactly 4 low cycles between last payload bit and next start bit.
- Assert reset during payload bit 10 with a word held → serial_o, busy_o, ready_o 0 immediately; after release, no frame is sent until a new word is accepted.
